// File: rtl/fsm_seq_pkg.sv
// Shared types and helpers for the serial sequence detector.
// The border function gives KMP-style fallback lengths on an MSB-first pattern.
package fsm_seq_pkg;

    localparam int unsigned MAX_PAT = 32;
    localparam int unsigned IDX_W   = $clog2(MAX_PAT);

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP,
        ACT_MATCH
    } act_e;

    function automatic int unsigned state_w(input int unsigned pat_len);
        int unsigned w;
        if (pat_len < 2) w = 1;
        else             w = $clog2(pat_len);
        return w;
    endfunction

    // Longest proper prefix of the first k bits of pat (MSB-first, plen bits)
    // that is also a suffix of those k bits.
    function automatic int unsigned border_len(input logic [MAX_PAT-1:0] pat,
                                               input int unsigned       plen,
                                               input int unsigned       k);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned j = 1; j < MAX_PAT; j++) begin
            if (j < k) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < MAX_PAT; i++) begin
                    if (i < j) begin
                        if (pat[IDX_W'(plen - 1 - i)] != pat[IDX_W'(plen - 1 - (k - j + i))])
                            ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/fsm_seq_detect_if.sv
// Serial-stream, control and status bundle of the sequence detector.
interface fsm_seq_detect_if #(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned SW = fsm_seq_pkg::state_w(PAT_LEN);

    logic               en;
    logic               in;
    logic               load;
    logic [PAT_LEN-1:0] pattern;
    logic               clear;
    logic [SW-1:0]      state;
    logic               detect;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output en, in, load, pattern, clear,
        input  state, detect, match_cnt
    );

    modport slave (
        input  en, in, load, pattern, clear,
        output state, detect, match_cnt
    );

endinterface

// File: rtl/fsm_seq_next.sv
// Combinational next-match-length function of the detector.
module fsm_seq_next
    import fsm_seq_pkg::*;
#(
    parameter  int unsigned PAT_LEN = 4,
    localparam int unsigned SW      = state_w(PAT_LEN),
    localparam int unsigned KW      = $clog2(PAT_LEN + 1)
) (
    input  logic [SW-1:0]      state_i,
    input  logic               in_i,
    input  logic [PAT_LEN-1:0] pattern_i,
    output logic [KW-1:0]      next_k_o,
    output logic               full_match_o
);

    logic [MAX_PAT-1:0] pat_ext;
    logic [MAX_PAT-1:0] trial;
    int unsigned        k;
    int unsigned        nk;

    // On a mismatch, splice the new bit into the pattern at the current
    // position; the border of that prefix is the longest surviving match.
    always_comb begin
        pat_ext                = '0;
        pat_ext[PAT_LEN-1:0]   = pattern_i;
        trial                  = pat_ext;
        k                      = 32'(state_i);
        nk                     = 0;
        if (k < PAT_LEN) begin
            if (in_i == pat_ext[IDX_W'(PAT_LEN - 1 - k)]) begin
                nk = k + 1;
            end else begin
                trial[IDX_W'(PAT_LEN - 1 - k)] = in_i;
                nk = border_len(trial, PAT_LEN, k + 1);
            end
        end
    end

    assign next_k_o     = KW'(nk);
    assign full_match_o = (nk == PAT_LEN);

endmodule

// File: rtl/fsm_seq_detect.sv
// Parametrised serial sequence detector with reloadable pattern and
// saturating match counter.
module fsm_seq_detect
    import fsm_seq_pkg::*;
#(
    parameter int unsigned        PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011,
    parameter bit                 OVERLAP     = 1'b1,
    parameter int unsigned        CNT_W       = 8
) (
    input logic            clk,
    input logic            rst,
    fsm_seq_detect_if.slave bus
);

    localparam int unsigned SW = state_w(PAT_LEN);
    localparam int unsigned KW = $clog2(PAT_LEN + 1);

    logic [SW-1:0]      state_q, state_d;
    logic               detect_q, detect_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;

    logic [KW-1:0]      next_k;
    logic               full_match;
    logic [SW-1:0]      ovl_k;
    logic [MAX_PAT-1:0] pat_ext;
    act_e               act;

    fsm_seq_next #(.PAT_LEN(PAT_LEN)) u_next (
        .state_i      (state_q),
        .in_i         (bus.in),
        .pattern_i    (pat_q),
        .next_k_o     (next_k),
        .full_match_o (full_match)
    );

    always_comb begin
        pat_ext              = '0;
        pat_ext[PAT_LEN-1:0] = pat_q;
        ovl_k                = SW'(border_len(pat_ext, PAT_LEN, PAT_LEN));
    end

    always_comb begin
        act = ACT_HOLD;
        if (bus.load)        act = ACT_LOAD;
        else if (bus.en)     act = full_match ? ACT_MATCH : ACT_STEP;
    end

    always_comb begin
        state_d  = state_q;
        detect_d = 1'b0;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        unique case (act)
            ACT_LOAD: begin
                pat_d   = bus.pattern;
                state_d = '0;
            end
            ACT_STEP: begin
                state_d = SW'(next_k);
            end
            ACT_MATCH: begin
                detect_d = 1'b1;
                cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                state_d  = OVERLAP ? ovl_k : '0;
            end
            default: ;
        endcase
        if (bus.clear) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= '0;
            detect_q <= 1'b0;
            cnt_q    <= '0;
            pat_q    <= DEFAULT_PAT;
        end else begin
            state_q  <= state_d;
            detect_q <= detect_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.detect    = detect_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Directed bench: three detector variants (overlap, non-overlap, 2-bit counter)
// driven by a shared stimulus stream.
module tb_fsm_seq_detect;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fsm_seq_detect_if #(.PAT_LEN(4), .CNT_W(8)) ifa ();
    fsm_seq_detect_if #(.PAT_LEN(4), .CNT_W(8)) ifb ();
    fsm_seq_detect_if #(.PAT_LEN(4), .CNT_W(2)) ifc ();

    fsm_seq_detect #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    fsm_seq_detect #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));
    fsm_seq_detect #(.PAT_LEN(4), .DEFAULT_PAT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave));

    int s1  [7] = '{1, 0, 1, 1, 0, 1, 1};
    int ea1 [7] = '{1, 2, 3, 1, 2, 3, 1};
    int da1 [7] = '{0, 0, 0, 1, 0, 0, 1};
    int eb1 [7] = '{1, 2, 3, 0, 0, 1, 1};
    int db1 [7] = '{0, 0, 0, 1, 0, 0, 0};
    int ea3 [6] = '{1, 2, 3, 3, 3, 3};
    int da3 [6] = '{0, 0, 0, 1, 1, 1};
    int eb3 [6] = '{1, 2, 3, 0, 1, 2};
    int db3 [6] = '{0, 0, 0, 1, 0, 0};
    int ec3 [6] = '{2, 2, 2, 3, 3, 3};
    int s6  [5] = '{0, 1, 1, 0, 1};
    int ea6 [5] = '{1, 2, 3, 1, 2};
    int da6 [5] = '{0, 0, 0, 1, 0};
    int s7  [4] = '{0, 1, 1, 0};
    int eb7 [4] = '{0, 1, 1, 2};

    task automatic drive(input logic e, input logic i, input logic l,
                         input logic c, input logic [3:0] p);
        ifa.en = e; ifa.in = i; ifa.load = l; ifa.clear = c; ifa.pattern = p;
        ifb.en = e; ifb.in = i; ifb.load = l; ifb.clear = c; ifb.pattern = p;
        ifc.en = e; ifc.in = i; ifc.load = l; ifc.clear = c; ifc.pattern = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        #2;
        chk("rst_a_state", 32'(ifa.state), 0);
        chk("rst_a_detect", 32'(ifa.detect), 0);
        chk("rst_a_cnt", 32'(ifa.match_cnt), 0);
        chk("rst_c_cnt", 32'(ifc.match_cnt), 0);
        #10 rst = 1'b1;

        // 1011 stream, overlap vs non-overlap; pattern input ignored without load
        for (int n = 0; n < 7; n++) begin
            drive(1'b1, s1[n] != 0, 1'b0, 1'b0, 4'b0000);
            tick();
            chk("t1_a_state", 32'(ifa.state), ea1[n]);
            chk("t1_a_detect", 32'(ifa.detect), da1[n]);
            chk("t1_b_state", 32'(ifb.state), eb1[n]);
            chk("t1_b_detect", 32'(ifb.detect), db1[n]);
        end
        chk("t1_a_cnt", 32'(ifa.match_cnt), 2);
        chk("t1_b_cnt", 32'(ifb.match_cnt), 1);
        chk("t1_c_cnt", 32'(ifc.match_cnt), 2);

        // load 1111 while en=1: bit discarded, state reset
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
        tick();
        chk("t3_load_a_state", 32'(ifa.state), 0);
        chk("t3_load_a_detect", 32'(ifa.detect), 0);
        chk("t3_load_a_cnt", 32'(ifa.match_cnt), 2);
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
            tick();
            chk("t3_a_state", 32'(ifa.state), ea3[n]);
            chk("t3_a_detect", 32'(ifa.detect), da3[n]);
            chk("t3_b_state", 32'(ifb.state), eb3[n]);
            chk("t3_b_detect", 32'(ifb.detect), db3[n]);
            chk("t3_c_cnt", 32'(ifc.match_cnt), ec3[n]);
        end
        chk("t3_a_cnt", 32'(ifa.match_cnt), 5);
        chk("t3_b_cnt", 32'(ifb.match_cnt), 2);

        // en gaps are transparent
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011);
        tick();
        chk("t4_load_a_state", 32'(ifa.state), 0);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, s1[n] != 0, 1'b0, 1'b0, 4'b1011);
            tick();
        end
        chk("t4_a_state3", 32'(ifa.state), 3);
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, n[0], 1'b0, 1'b0, 4'b1011);
            tick();
            chk("t4_gap_a_state", 32'(ifa.state), 3);
            chk("t4_gap_a_detect", 32'(ifa.detect), 0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
        tick();
        chk("t4_a_detect", 32'(ifa.detect), 1);
        chk("t4_a_state", 32'(ifa.state), 1);
        chk("t4_b_detect", 32'(ifb.detect), 1);
        chk("t4_b_state", 32'(ifb.state), 0);
        chk("t4_a_cnt", 32'(ifa.match_cnt), 6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
        tick();
        chk("t4_a_detect_drop", 32'(ifa.detect), 0);
        chk("t4_a_state_hold", 32'(ifa.state), 1);

        // counter saturation on CNT_W=2, then clear coinciding with a match
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
        tick();
        chk("t5_clear_c_cnt", 32'(ifc.match_cnt), 0);
        chk("t5_clear_a_cnt", 32'(ifa.match_cnt), 0);
        for (int m = 0; m < 5; m++) begin
            for (int n = 0; n < 4; n++) begin
                drive(1'b1, s1[n] != 0, 1'b0, 1'b0, 4'b1011);
                tick();
            end
            chk("t5_c_detect", 32'(ifc.detect), 1);
            chk("t5_c_cnt", 32'(ifc.match_cnt), (m < 3) ? m + 1 : 3);
            chk("t5_a_cnt", 32'(ifa.match_cnt), m + 1);
        end
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, s1[n] != 0, 1'b0, 1'b0, 4'b1011);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
        tick();
        chk("t5_clr_c_detect", 32'(ifc.detect), 1);
        chk("t5_clr_c_cnt", 32'(ifc.match_cnt), 0);
        chk("t5_clr_a_detect", 32'(ifa.detect), 1);
        chk("t5_clr_a_cnt", 32'(ifa.match_cnt), 0);

        // load 0110, match once, reach state 2, then async reset mid-stream
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110);
        tick();
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, s6[n] != 0, 1'b0, 1'b0, 4'b0110);
            tick();
            chk("t6_a_state", 32'(ifa.state), ea6[n]);
            chk("t6_a_detect", 32'(ifa.detect), da6[n]);
        end
        chk("t6_a_cnt", 32'(ifa.match_cnt), 1);
        chk("t6_b_cnt", 32'(ifb.match_cnt), 1);
        rst = 1'b0;
        #2;
        chk("t6_rst_a_state", 32'(ifa.state), 0);
        chk("t6_rst_a_detect", 32'(ifa.detect), 0);
        chk("t6_rst_a_cnt", 32'(ifa.match_cnt), 0);
        chk("t6_rst_b_cnt", 32'(ifb.match_cnt), 0);
        #3 rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, s1[n] != 0, 1'b0, 1'b0, 4'b0110);
            tick();
        end
        chk("t6_def_a_detect", 32'(ifa.detect), 1);
        chk("t6_def_b_detect", 32'(ifb.detect), 1);
        chk("t6_def_a_state", 32'(ifa.state), 1);
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, s7[n] != 0, 1'b0, 1'b0, 4'b0110);
            tick();
            chk("t6_0110_b_detect", 32'(ifb.detect), 0);
            chk("t6_0110_b_state", 32'(ifb.state), eb7[n]);
        end
        chk("t6_b_cnt_final", 32'(ifb.match_cnt), 1);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
